// File: rtl/id_token_capture_pkg.sv
// Shared constants for the identifier token capture block: buffer depth,
// FSM state encoding and the ASCII ranges used by the character classifier.
package id_token_capture_pkg;

    localparam int ID_MAX_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALPHA = 2'd1,
        ST_DIGIT = 2'd2
    } state_t;

    localparam logic [7:0] CH_LOWER_A = 8'h61;  // "a"
    localparam logic [7:0] CH_LOWER_Z = 8'h7A;  // "z"
    localparam logic [7:0] CH_UPPER_A = 8'h41;  // "A"
    localparam logic [7:0] CH_UPPER_Z = 8'h5A;  // "Z"
    localparam logic [7:0] CH_ZERO    = 8'h30;  // "0"
    localparam logic [7:0] CH_NINE    = 8'h39;  // "9"

endpackage

// File: rtl/id_token_capture_char_class.sv
// Combinational ASCII classifier: letter, digit, or neither.
module id_char_class
    import id_token_capture_pkg::*;
(
    input  logic [7:0] char,
    output logic       is_letter,
    output logic       is_digit
);

    // Range compares against the shared ASCII bounds.
    always_comb begin
        is_letter = ((char >= CH_LOWER_A) && (char <= CH_LOWER_Z)) ||
                    ((char >= CH_UPPER_A) && (char <= CH_UPPER_Z));
        is_digit  = (char >= CH_ZERO) && (char <= CH_NINE);
    end

endmodule

// File: rtl/id_token_capture.sv
// Captures letters+digits identifiers from an ASCII stream and presents them
// through a single-entry valid/ready output register.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | no identifier in progress, buffer empty
// ST_ALPHA | collecting the leading letters of a candidate identifier
// ST_DIGIT | letters+digits seen; next non-digit terminates the token
module id_token_capture #(
    parameter int ID_MAX_LEN = id_token_capture_pkg::ID_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char,
    input  logic        match,
    output logic [63:0] tok_data,
    output logic [3:0]  tok_len,
    output logic        tok_trunc,
    output logic        tok_valid,
    input  logic        tok_ready,
    output logic [15:0] tok_count,
    output logic [7:0]  drop_count,
    output logic        sync_err
);
    import id_token_capture_pkg::*;

    localparam logic [3:0] LEN_MAX = 4'(ID_MAX_LEN);

    state_t      state;
    state_t      nxt_state;
    logic [7:0]  d_char;
    logic [63:0] buf_data;
    logic [3:0]  buf_len;
    logic        buf_trunc;
    logic        is_letter;
    logic        is_digit;
    logic        emit;
    logic        do_load;
    logic        do_append;
    logic        do_clear;

    // Classify the delayed char so it lines up with the registered match.
    id_char_class u_class (
        .char      (d_char),
        .is_letter (is_letter),
        .is_digit  (is_digit)
    );

    // Next-state and buffer action decode for the current char.
    always_comb begin
        nxt_state = state;
        emit      = 1'b0;
        do_load   = 1'b0;
        do_append = 1'b0;
        do_clear  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_letter) begin
                    nxt_state = ST_ALPHA;
                    do_load   = 1'b1;
                end
            end
            ST_ALPHA: begin
                if (is_letter) begin
                    do_append = 1'b1;
                end else if (is_digit) begin
                    nxt_state = ST_DIGIT;
                    do_append = 1'b1;
                end else begin
                    nxt_state = ST_IDLE;
                    do_clear  = 1'b1;
                end
            end
            ST_DIGIT: begin
                if (is_digit) begin
                    do_append = 1'b1;
                end else if (is_letter) begin
                    nxt_state = ST_ALPHA;
                    emit      = 1'b1;
                    do_load   = 1'b1;
                end else begin
                    nxt_state = ST_IDLE;
                    emit      = 1'b1;
                    do_clear  = 1'b1;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                do_clear  = 1'b1;
            end
        endcase
    end

    // FSM, char delay, token buffer and sticky matcher cross-check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            d_char    <= 8'd0;
            buf_data  <= 64'd0;
            buf_len   <= 4'd0;
            buf_trunc <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            d_char <= char;
            state  <= nxt_state;
            if ((nxt_state == ST_DIGIT) != match) begin
                sync_err <= 1'b1;
            end
            if (do_load) begin
                buf_data  <= {56'd0, d_char};
                buf_len   <= 4'd1;
                buf_trunc <= 1'b0;
            end else if (do_append) begin
                // A full buffer keeps its first chars and only flags the overflow.
                if (buf_len >= LEN_MAX) begin
                    buf_trunc <= 1'b1;
                end else begin
                    buf_data[{buf_len[2:0], 3'b000} +: 8] <= d_char;
                    buf_len <= buf_len + 4'd1;
                end
            end else if (do_clear) begin
                buf_data  <= 64'd0;
                buf_len   <= 4'd0;
                buf_trunc <= 1'b0;
            end
        end
    end

    // Output register with handshake, accepted/dropped counters (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_data   <= 64'd0;
            tok_len    <= 4'd0;
            tok_trunc  <= 1'b0;
            tok_valid  <= 1'b0;
            tok_count  <= 16'd0;
            drop_count <= 8'd0;
        end else if (emit) begin
            if (!tok_valid || tok_ready) begin
                tok_data  <= buf_data;
                tok_len   <= buf_len;
                tok_trunc <= buf_trunc;
                tok_valid <= 1'b1;
                if (tok_count != 16'hFFFF) begin
                    tok_count <= tok_count + 16'd1;
                end
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (tok_ready) begin
            tok_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_token_capture.md
ID_TOKEN_CAPTURE -- requirements
Module: id_token_capture

Interface
REQ-001 SHALL have ports, one per line below: name  direction  width  meaning.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 char  input  8  ASCII stream, one char per cycle, identical to the stream driving the identifier matcher.
REQ-005 match  input  1  registered matcher output; high in cycle n when the char of cycle n-1 completed a letters+digits identifier.
REQ-006 tok_data  output  64  captured token; char k in bits [8k+7:8k], unused bytes zero.
REQ-007 tok_len  output  4  captured char count, 1..8.
REQ-008 tok_trunc  output  1  token exceeded 8 chars; only the first 8 are kept.
REQ-009 tok_valid / tok_ready  output / input  1 / 1  token handshake; transfer when both high on a posedge.
REQ-010 tok_count  output  16  tokens accepted into the output register, saturating at 65535.
REQ-011 drop_count  output  8  tokens lost to output back-pressure, saturating at 255.
REQ-012 sync_err  output  1  sticky; internal classification disagreed with match.
REQ-013 Parameter ID_MAX_LEN, default 8, meaning token buffer depth in chars (fixed at 8 for this port widths).

Function
REQ-014 SHALL register char into d_char each cycle so that d_char and match describe the same character c in cycle n.
REQ-015 SHALL classify c as LETTER (a-z, A-Z), DIGIT (0-9) or OTHER.
REQ-016 FSM states IDLE, ALPHA, DIGIT; IDLE: LETTER -> buffer={c}, len=1, ALPHA; else stay IDLE.
REQ-017 ALPHA: LETTER -> append, stay; DIGIT -> append, go DIGIT; OTHER -> clear buffer, IDLE, no emission.
REQ-018 DIGIT: DIGIT -> append, stay; LETTER -> emit token, buffer={c}, len=1, ALPHA (same cycle); OTHER -> emit token, clear, IDLE.
REQ-019 Append at len=8 SHALL discard c, hold len=8 and set the token's trunc bit.
REQ-020 Emitted token SHALL exclude the terminating char c.
REQ-021 sync_err SHALL set when (next state == DIGIT) differs from match; cleared only by reset.
REQ-022 Emission SHALL load tok_data/tok_len/tok_trunc and assert tok_valid at the same posedge (visible cycle n+1) if tok_valid is low or tok_ready is high that cycle; tok_count increments.
REQ-023 Emission while tok_valid high and tok_ready low SHALL leave the output register unchanged and increment drop_count.
REQ-024 tok_valid SHALL clear after a transfer with no simultaneous emission; outputs SHALL hold stable while tok_valid high and tok_ready low.
REQ-025 Both counters SHALL saturate, never wrap.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, d_char 0, buffer/len/trunc 0, all outputs 0.
REQ-027 Reset mid-token or with tok_valid high SHALL discard the token without counting it as dropped.

Structure
REQ-028 Shared package SHALL hold ID_MAX_LEN, state encoding, and ASCII range constants ("a","z","A","Z","0","9").
REQ-029 Classification SHALL be one combinational sub-module id_char_class (in char, out is_letter, is_digit).
REQ-030 Implementation SHALL be a single always block for the FSM/buffer and one for the output register and counters.

Verification (chars shown in aligned cycle order, matcher driven from same stream)
REQ-031 "ab12 " with tok_ready=1 -> one token, tok_data bytes "a","b","1","2", tok_len=4, tok_trunc=0, tok_valid one cycle after the space.
REQ-032 "x1y2;" -> two tokens "x1" then "y2", each tok_len=2, tok_count=2.
REQ-033 "abcdefgh12 " -> tok_len=8, bytes "abcdefgh", tok_trunc=1.
REQ-034 "ab;cd " -> no token, tok_count=0, sync_err=0.
REQ-035 tok_ready=0, stream "a1 b2 " -> "a1" held, "b2" dropped, drop_count=1, tok_count=1; raising tok_ready then clears tok_valid.
REQ-036 Assert rst_n low after "ab1" -> all outputs 0 at once; a following "c3 " yields only token "c3".
